// File: rtl/clk_div_pkg.sv
// Shared widths, reset defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEFAULT = 13;
    localparam int unsigned CH_IDX_W      = 4;
    localparam int unsigned DIV_DEFAULT   = 1;
    localparam int unsigned HIGH_DEFAULT  = 1;

    // Output level for a count: high while the count is below the high count.
    // Arguments are widened to 32 bits so any CNT_W up to 31 compares correctly.
    function automatic logic below_high(input logic [31:0] cnt, input logic [31:0] high);
        return cnt < high;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow configuration, divided clock and rise strobe.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned DEF_DIV  = DIV_DEFAULT,
    parameter int unsigned DEF_HIGH = HIGH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W:0]   wr_high,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_a;
    logic [CNT_W:0]   high_a;
    logic [CNT_W-1:0] div_s;
    logic [CNT_W:0]   high_s;

    logic             wrap_c;
    logic             apply_c;
    logic [CNT_W-1:0] div_nx_c;
    logic [CNT_W:0]   high_nx_c;
    logic [CNT_W-1:0] cnt_nx_c;
    logic             out_nx_c;

    // Next count and level; a pending shadow takes effect at a wrap (or at once when idle)
    // so the first new period starts exactly at count 0.
    always_comb begin
        wrap_c    = 1'b0;
        apply_c   = 1'b0;
        div_nx_c  = div_a;
        high_nx_c = high_a;
        cnt_nx_c  = div_a;
        out_nx_c  = 1'b0;
        if (en) begin
            wrap_c = sync || (cnt >= div_a);
        end
        apply_c = pending && (wrap_c || !en);
        if (apply_c) begin
            div_nx_c  = div_s;
            high_nx_c = high_s;
        end
        if (en) begin
            cnt_nx_c = wrap_c ? '0 : cnt + CNT_W'(1);
            out_nx_c = below_high(32'(cnt_nx_c), 32'(high_nx_c));
        end else begin
            // Parking at the divide factor makes the first enabled edge a wrap.
            cnt_nx_c = div_nx_c;
        end
    end

    // Counter, active configuration and output flops.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt      <= CNT_W'(DEF_DIV);
            div_a    <= CNT_W'(DEF_DIV);
            high_a   <= (CNT_W+1)'(DEF_HIGH);
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
        end else begin
            cnt      <= cnt_nx_c;
            div_a    <= div_nx_c;
            high_a   <= high_nx_c;
            clk_out  <= out_nx_c;
            rise_stb <= out_nx_c & ~clk_out;
        end
    end

    // Shadow registers; an accept can never coincide with an apply since ready was low.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_s   <= CNT_W'(DEF_DIV);
            high_s  <= (CNT_W+1)'(DEF_HIGH);
            pending <= 1'b0;
        end else if (wr) begin
            div_s   <= wr_div;
            high_s  <= wr_high;
            pending <= 1'b1;
        end else if (apply_c) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free reprogramming and global sync.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned DEF_DIV  = DIV_DEFAULT,
    parameter int unsigned DEF_HIGH = HIGH_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [N_CH-1:0]     en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W:0]      cfg_high,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     rise_stb
);

    localparam int unsigned MAX_CH = 1 << CH_IDX_W;

    logic [N_CH-1:0]   pending;
    logic [MAX_CH-1:0] pend_ext;
    logic [N_CH-1:0]   wr;

    // Ready mux; writes to channels that do not exist are accepted and dropped.
    always_comb begin
        pend_ext  = MAX_CH'(pending);
        cfg_ready = (32'(cfg_ch) >= N_CH) || !pend_ext[cfg_ch];
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Per-channel write strobe decoded from the shared cfg port.
        assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_IDX_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_HIGH(DEF_HIGH)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
            .clk_out (clk_out[i]),
            .rise_stb(rise_stb[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: phase-based reference model plus directed scenarios.
module tb_clk_div_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 13;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic [N_CH-1:0]   en = '0;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W:0]    cfg_high = '0;
    logic [N_CH-1:0]   clk_out;
    logic [N_CH-1:0]   rise_stb;

    int n_checks = 0;
    int n_errors = 0;
    int rise_tally [N_CH];

    clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(1), .DEF_HIGH(1)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .clk_out  (clk_out),
        .rise_stb (rise_stb)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: position within the period ----------------
    int        m_phase [N_CH];
    int        m_div   [N_CH];
    int        m_high  [N_CH];
    int        m_sdiv  [N_CH];
    int        m_shigh [N_CH];
    bit        m_pend  [N_CH];
    bit        m_valid = 0;
    logic [N_CH-1:0] e_out = '0;
    logic [N_CH-1:0] e_rise = '0;

    always @(posedge clk_in) begin
        bit acc [N_CH];
        bit wrap;
        bit lvl;
        for (int c = 0; c < N_CH; c++)
            acc[c] = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
        m_valid = 1;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_phase[c] = 1; m_div[c] = 1; m_high[c] = 1;
                m_sdiv[c] = 1; m_shigh[c] = 1; m_pend[c] = 0;
            end
            e_out = '0;
            e_rise = '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (en[c]) begin
                    wrap = sync || (m_phase[c] >= m_div[c]);
                    if (wrap && m_pend[c]) begin
                        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
                    end
                    m_phase[c] = wrap ? 0 : m_phase[c] + 1;
                    lvl = (m_phase[c] < m_high[c]);
                end else begin
                    if (m_pend[c]) begin
                        m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c]; m_pend[c] = 0;
                    end
                    m_phase[c] = m_div[c];
                    lvl = 0;
                end
                e_rise[c] = lvl && !e_out[c];
                e_out[c]  = lvl;
                if (acc[c]) begin
                    m_sdiv[c] = int'(cfg_div); m_shigh[c] = int'(cfg_high); m_pend[c] = 1;
                end
            end
        end
    end

    // Compare process on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        bit exp_ready;
        if (m_valid) begin
            exp_ready = (int'(cfg_ch) >= N_CH) ? 1'b1 : !m_pend[cfg_ch[1:0]];
            check("model_clk_out", 32'(clk_out), 32'(e_out));
            check("model_rise_stb", 32'(rise_stb), 32'(e_rise));
            check("model_cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
        for (int c = 0; c < N_CH; c++) rise_tally[c] += int'(rise_stb[c]);
    endtask

    task automatic write_cfg(input logic [3:0] ch, input int d, input int h);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = CNT_W'(d);
        cfg_high  = (CNT_W+1)'(h);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input logic [3:0] ch, input string name);
        bit ok;
        ok = 0;
        cfg_ch = ch;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            ok = cfg_ready;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [9:0] pat;
        int base;
        int ones;
        bit found;
        for (int c = 0; c < N_CH; c++) rise_tally[c] = 0;

        // Reset state
        step(); step();
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_rise_stb", 32'(rise_stb), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);

        // Defaults on ch0: 1,0,1,0 from the cycle after en
        rst = 1'b0;
        en  = 4'b0001;
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            pat = {pat[8:0], clk_out[0]};
            check("t1_rise_eq_high", 32'(rise_stb[0]), 32'(clk_out[0]));
        end
        check("t1_ch0_pattern", 32'(pat[3:0]), 32'b1010);
        check("t1_other_low", 32'(clk_out[3:1]), 32'd0);

        // ch1 D=4,H=2: ready drops, then 1,1,0,0,0 from the apply wrap
        en = 4'b0011;
        step(); step(); step();
        write_cfg(4'd1, 4, 2);
        check("t2_ready_drop", 32'(cfg_ready), 32'd0);
        wait_ready(4'd1, "t2_apply_timeout");
        base = rise_tally[1] - int'(rise_stb[1]);
        pat = {9'd0, clk_out[1]};
        for (int k = 0; k < 9; k++) begin
            step();
            pat = {pat[8:0], clk_out[1]};
        end
        check("t2_ch1_pattern", 32'(pat), 32'b1100011000);
        check("t2_ch1_rises", 32'(rise_tally[1] - base), 32'd2);

        // ch2 H=0 constant low, then H=10 constant high with one strobe
        en = 4'b0111;
        step(); step();
        write_cfg(4'd2, 9, 0);
        wait_ready(4'd2, "t3a_apply_timeout");
        ones = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            ones += int'(clk_out[2]);
        end
        check("t3_h0_ones", 32'(ones), 32'd0);
        base = rise_tally[2];
        write_cfg(4'd2, 9, 10);
        wait_ready(4'd2, "t3b_apply_timeout");
        for (int k = 0; k < 25; k++) step();
        check("t3_ch2_single_rise", 32'(rise_tally[2] - base), 32'd1);
        check("t3_ch2_high", 32'(clk_out[2]), 32'd1);

        // ch0 D=2, ch1 D=6, then sync realigns all enabled channels
        write_cfg(4'd0, 2, 1);
        wait_ready(4'd0, "t4a_apply_timeout");
        write_cfg(4'd1, 6, 2);
        wait_ready(4'd1, "t4b_apply_timeout");
        step(); step();
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            found = (clk_out[1:0] == 2'b00);
        end
        check("t4_both_low_timeout", 32'(found), 32'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t4_sync_clk_out", 32'(clk_out), 32'b0111);
        check("t4_sync_rise", 32'(rise_stb), 32'b0011);
        step();
        check("t4_after_sync", 32'(clk_out[1:0]), 32'b10);

        // ch3 second write while pending is refused; out-of-range channel is swallowed
        write_cfg(4'd3, 5, 3);
        check("t5_ready_pending", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(7);
        cfg_high  = (CNT_W+1)'(1);
        step();
        cfg_valid = 1'b0;
        check("t5_ready_after", 32'(cfg_ready), 32'd1);
        cfg_ch = 4'd7;
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(3);
        cfg_high  = (CNT_W+1)'(2);
        #1;
        check("t5_ready_ch7", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        en = 4'b1111;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            pat = {pat[8:0], clk_out[3]};
        end
        check("t5_ch3_first_value", 32'(pat[5:0]), 32'b111000);

        // Reset mid-period with a pending write on ch0
        write_cfg(4'd1, 4, 2);
        wait_ready(4'd1, "t6_apply_timeout");
        step(); step();
        write_cfg(4'd0, 8, 4);
        rst = 1'b1;
        cfg_ch = 4'd0;
        step();
        check("t6_rst_clk_out", 32'(clk_out), 32'd0);
        check("t6_rst_rise", 32'(rise_stb), 32'd0);
        check("t6_rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        en  = 4'b0011;
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            pat = {pat[8:0], clk_out[0]};
            check("t6_ch1_default", 32'(clk_out[1]), 32'(clk_out[0]));
        end
        check("t6_ch0_default", 32'(pat[3:0]), 32'b1010);

        en = '0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
